// File: rtl/reg_writeback_if.sv
// reg_writeback_if: producer and register-file signals of the write-back front end.
//   ALU producer  : alu_valid, alu_ready, alu_rd[4:0], alu_data[31:0]
//   Load producer : ld_valid, ld_ready, ld_rd[4:0], ld_data[31:0]
//   Reg-file port : write_enable, write_addr[4:0], write_data[31:0]
//   Status        : alu_count (ALU FIFO occupancy)
// The slave modport is the write-back block; the master modport is its environment.
interface reg_writeback_if #(
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_rd;
  logic [31:0]       alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [4:0]        ld_rd;
  logic [31:0]       ld_data;
  logic              write_enable;
  logic [4:0]        write_addr;
  logic [31:0]       write_data;
  logic [CNT_W-1:0]  alu_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, write_enable, write_addr, write_data, alu_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, write_enable, write_addr, write_data, alu_count
  );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: write-side front end of the 32x32 integer register file.
// Merges the single-cycle ALU result stream and the multi-cycle load result
// stream onto the register file's single write port. ALU results go through
// a DEPTH-entry FIFO; a load handshake always wins the port, except that a
// full FIFO drops ld_ready so the FIFO head drains.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active-high (overrides clk_enable_n)
//   clk_enable_n : 1 = advance, 0 = hold all state and block handshakes
//   bus          : reg_writeback_if.slave (producers, write port, occupancy)
module reg_writeback #(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_enable_n,
  reg_writeback_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       r_mem_rd   [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_we;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;

  logic             w_alu_ready;
  logic             w_ld_ready;
  logic             w_push;
  logic             w_ld_take;
  logic             w_pop;
  logic             w_sel;
  logic [4:0]       w_sel_rd;
  logic [31:0]      w_sel_data;

  // Readies depend only on registered occupancy and the enable, never on valids.
  assign w_alu_ready = clk_enable_n && (r_count < CNT_W'(DEPTH));
  assign w_ld_ready  = clk_enable_n && (r_count != CNT_W'(DEPTH));

  assign w_push    = bus.alu_valid && w_alu_ready;
  assign w_ld_take = bus.ld_valid  && w_ld_ready;
  // The FIFO head is popped only when no load claims the port this edge.
  assign w_pop     = clk_enable_n && !w_ld_take && (r_count != '0);

  always_comb begin
    w_sel      = 1'b0;
    w_sel_rd   = r_mem_rd[r_rptr];
    w_sel_data = r_mem_data[r_rptr];
    if (w_ld_take) begin
      w_sel      = 1'b1;
      w_sel_rd   = bus.ld_rd;
      w_sel_data = bus.ld_data;
    end else if (w_pop) begin
      w_sel      = 1'b1;
    end
  end

  // FIFO storage: data only, no reset needed since pointers/count are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= bus.alu_rd;
      r_mem_data[r_wptr] <= bus.alu_data;
    end
  end

  // Control and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (clk_enable_n) begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // x0-destined items are consumed but never written.
      r_we <= w_sel && (w_sel_rd != 5'd0);
      if (w_sel) begin
        r_waddr <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign bus.alu_ready    = w_alu_ready;
  assign bus.ld_ready     = w_ld_ready;
  assign bus.write_enable = r_we;
  assign bus.write_addr   = r_waddr;
  assign bus.write_data   = r_wdata;
  assign bus.alu_count    = r_count;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed bench for reg_writeback (DEPTH = 2) with a
// cycle model of the FIFO/arbiter and a scoreboard of expected writes.
module tb_reg_writeback;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } item_t;

  logic clk;
  logic rst;
  logic clk_enable_n;

  reg_writeback_if #(.DEPTH(DEPTH)) bus();

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_enable_n (clk_enable_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  item_t m_q[$];
  item_t exp_q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int    alu_seen = 0;
  logic  aa, al;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic en);
    rst = 1'b1;
    clk_enable_n = en;
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
    chk("rst_we",    bus.write_enable, 0);
    chk("rst_addr",  bus.write_addr,   0);
    chk("rst_data",  bus.write_data,   0);
    chk("rst_count", bus.alu_count,    0);
  endtask

  // One clock: drive inputs, check readies, advance model and DUT, compare.
  task automatic cycle(input logic en, input logic av, input logic [4:0] ar,
                       input logic [31:0] ad, input logic lv, input logic [4:0] lr,
                       input logic [31:0] ldd, output logic acc_a, output logic acc_l);
    item_t sel;
    item_t got;
    logic  have;
    clk_enable_n  = en;
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lr;
    bus.ld_data   = ldd;
    acc_a = en && av && (m_q.size() < DEPTH);
    acc_l = en && lv && (m_q.size() != DEPTH);
    #1;
    chk("alu_ready", bus.alu_ready, en && (m_q.size() < DEPTH));
    chk("ld_ready",  bus.ld_ready,  en && (m_q.size() != DEPTH));
    @(posedge clk);
    #1;
    if (en) begin
      have = 1'b0;
      sel  = '0;
      if (acc_l) begin
        have = 1'b1;
        sel.rd = lr;
        sel.data = ldd;
      end else if (m_q.size() > 0) begin
        have = 1'b1;
        sel = m_q.pop_front();
      end
      if (acc_a) begin
        got.rd = ar;
        got.data = ad;
        m_q.push_back(got);
      end
      m_we = have && (sel.rd != 5'd0);
      if (have) begin
        m_addr = sel.rd;
        m_data = sel.data;
      end
      if (m_we) exp_q.push_back(sel);
    end
    chk("we",    bus.write_enable, m_we);
    chk("addr",  bus.write_addr,   m_addr);
    chk("data",  bus.write_data,   m_data);
    chk("count", bus.alu_count,    m_q.size());
    if (bus.write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", bus.write_addr, 32'hFFFF_FFFF);
      end else begin
        got = exp_q.pop_front();
        chk("sb_addr", bus.write_addr, got.rd);
        chk("sb_data", bus.write_data, got.data);
      end
      if (bus.write_addr >= 5'd16 && bus.write_addr < 5'd24) begin
        chk("alu_order", bus.write_addr, 16 + alu_seen);
        alu_seen++;
      end
    end
  endtask

  task automatic idle();
    logic x, y;
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, x, y);
  endtask

  initial begin
    int   na;
    int   nl;
    logic saw_full;
    rst = 1'b0;
    clk_enable_n = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;

    // Reset (taken even with the enable low), then idle.
    do_reset(1'b0);
    idle();

    // Single ALU result.
    cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, aa, al);
    chk("alu1_count", bus.alu_count, 1);
    chk("alu1_we_e1", bus.write_enable, 0);
    idle();
    chk("alu1_we",   bus.write_enable, 1);
    chk("alu1_addr", bus.write_addr,   5);
    chk("alu1_data", bus.write_data,   32'hDEADBEEF);
    idle();
    chk("alu1_we_off", bus.write_enable, 0);

    // ALU and load offered together: load first, ALU buffered.
    cycle(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, aa, al);
    chk("both_ld_addr", bus.write_addr, 4);
    chk("both_ld_data", bus.write_data, 32'h22);
    chk("both_count",   bus.alu_count,  1);
    idle();
    chk("both_alu_addr", bus.write_addr, 3);
    chk("both_alu_data", bus.write_data, 32'h11);
    idle();

    // Continuous load stream plus 8 ALU results: FIFO fills and drains.
    alu_seen = 0;
    na = 0;
    nl = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 40 && na < 8; c++) begin
      cycle(1'b1, 1'b1, 5'(16 + na), 32'hA0 + 32'(na),
            1'b1, 5'(8 + (nl % 8)), 32'hB0 + 32'(nl), aa, al);
      if (aa) na++;
      if (al) nl++;
      if (bus.alu_count == 2) saw_full = 1'b1;
    end
    for (int c = 0; c < 4; c++) idle();
    chk("stream_alu_accepted", na, 8);
    chk("stream_saw_full", saw_full, 1);
    chk("stream_alu_written", alu_seen, 8);
    chk("stream_sb_empty", exp_q.size(), 0);

    // x0 load is consumed silently; ALU rd=7 held through a 3-edge stall.
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, aa, al);
    chk("x0_accepted", al, 1);
    chk("x0_we", bus.write_enable, 0);
    cycle(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, aa, al);
    chk("x0_count", bus.alu_count, 1);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, aa, al);
      chk("stall_count", bus.alu_count, 1);
      chk("stall_we",    bus.write_enable, 0);
    end
    idle();
    chk("stall_resume_addr", bus.write_addr, 7);
    chk("stall_resume_we",   bus.write_enable, 1);
    idle();

    // Reset with a full FIFO and a pending write.
    cycle(1'b1, 1'b1, 5'd13, 32'h13, 1'b1, 5'd12, 32'h12, aa, al);
    cycle(1'b1, 1'b1, 5'd14, 32'h14, 1'b1, 5'd15, 32'h15, aa, al);
    chk("pre_rst_count", bus.alu_count, 2);
    chk("pre_rst_we",    bus.write_enable, 1);
    do_reset(1'b1);
    for (int c = 0; c < 4; c++) begin
      idle();
      chk("post_rst_we", bus.write_enable, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
